// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// SPI slave standing in for a 12-bit two-channel ADC. The cs_n, sclk and mosi
// pins are sampled on clk and synchronised; the 4-bit command (start, SGL, ODD,
// MSBF) is decoded; and the selected channel word is returned MSB-first on miso.
// The word is aligned so that its MSB goes out on sclk fall MSB_EDGE.
// The control outputs settle 3 clk after each pin edge.
module adc_spi_responder #(
   parameter int DATA_W      = 12,
   parameter int MSB_EDGE    = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] ch0_data,
   input  logic [DATA_W-1:0] ch1_data,
   output logic [2:0]        cfg,
   output logic              cfg_valid,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WAIT_ST = 3'd1;
   localparam logic [2:0] CMD     = 3'd2;
   localparam logic [2:0] LEAD    = 3'd3;
   localparam logic [2:0] DATA    = 3'd4;
   localparam logic [2:0] TRAIL   = 3'd5;

   // Fall numbers (counted from the start-bit rise) carrying the MSB and the LSB
   localparam logic [4:0] MSB_FE = 5'(MSB_EDGE);
   localparam logic [4:0] LSB_FE = 5'(MSB_EDGE + DATA_W - 1);

   // Fall counter increment that sticks at its ceiling rather than wrapping
   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v == 5'd31) ? v : v + 5'd1;
   endfunction

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   cs_s;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   cs_p1;
   logic                   sclk_p1;

   logic [2:0]             state;
   logic [4:0]             fe_cnt;
   logic [4:0]             fe_next;
   logic [1:0]             cmd_cnt;
   logic [1:0]             cmd_sr;

   logic [DATA_W-1:0]      ch0_snap;
   logic [DATA_W-1:0]      ch1_snap;
   logic [DATA_W-1:0]      word_sr;

   logic                   cs_fall;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   closing;
   logic                   start_hit;
   logic                   cmd_done;
   logic                   shift_bit;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Synchronise the pins; keep one delayed copy of cs_n and sclk for edge detection.
   // The cs_n chain clears to 0, so a pin that is still low at release is not seen as a new fall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync   <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_p1     <= 1'b0;
         sclk_p1   <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_p1     <= cs_s;
         sclk_p1   <= sclk_s;
      end
   end

   // Edge strobes and frame events; a cs_n rise masks any coincident sclk edge
   always_comb begin
      cs_fall   = 1'b0;
      sclk_rise = 1'b0;
      sclk_fall = 1'b0;
      closing   = 1'b0;
      start_hit = 1'b0;
      cmd_done  = 1'b0;
      shift_bit = 1'b0;
      fe_next   = sat_inc(fe_cnt);
      cs_fall   = cs_p1 & ~cs_s;
      sclk_rise = sclk_s & ~sclk_p1;
      sclk_fall = ~sclk_s & sclk_p1;
      closing   = (state != IDLE) && cs_s;
      start_hit = !cs_s && (state == WAIT_ST) && sclk_rise && mosi_s;
      cmd_done  = !cs_s && (state == CMD) && sclk_rise && (cmd_cnt == 2'd2);
      shift_bit = !cs_s && sclk_fall &&
                  (((state == LEAD) && (fe_next == MSB_FE)) || (state == DATA));
   end

   // Channel snapshot at the start bit and the outgoing word shifter
   always_ff @(posedge clk) begin
      if (start_hit) begin
         ch0_snap <= ch0_data;
         ch1_snap <= ch1_data;
      end
      if (cmd_done) begin
         word_sr <= cmd_sr[0] ? ch1_snap : ch0_snap;
      end else if (shift_bit) begin
         word_sr <= {word_sr[DATA_W-2:0], 1'b0};
      end
   end

   // Frame state machine, command decode, miso drive and status pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         fe_cnt      <= '0;
         cmd_cnt     <= '0;
         cmd_sr      <= '0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         cfg         <= '0;
         cfg_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         cfg_valid   <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         if (closing) begin
            state       <= IDLE;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            frame_done  <= (state == TRAIL);
            frame_abort <= (state == CMD) || (state == LEAD) || (state == DATA);
         end else begin
            case (state)
               IDLE: begin
                  miso <= 1'b0;
                  if (cs_fall) begin
                     state   <= WAIT_ST;
                     miso_oe <= 1'b1;
                     fe_cnt  <= '0;
                     cmd_cnt <= '0;
                  end
               end
               WAIT_ST: begin
                  if (start_hit) begin
                     state   <= CMD;
                     fe_cnt  <= '0;
                     cmd_cnt <= '0;
                  end
               end
               CMD: begin
                  if (sclk_fall) begin
                     fe_cnt <= fe_next;
                  end
                  if (sclk_rise) begin
                     cmd_sr  <= {cmd_sr[0], mosi_s};
                     cmd_cnt <= cmd_cnt + 2'd1;
                  end
                  if (cmd_done) begin
                     cfg       <= {cmd_sr, mosi_s};
                     cfg_valid <= 1'b1;
                     state     <= LEAD;
                  end
               end
               LEAD: begin
                  if (sclk_fall) begin
                     fe_cnt <= fe_next;
                     miso   <= 1'b0;
                  end
                  if (shift_bit) begin
                     miso  <= word_sr[DATA_W-1];
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (shift_bit) begin
                     fe_cnt <= fe_next;
                     miso   <= word_sr[DATA_W-1];
                     if (fe_next == LSB_FE) begin
                        state <= TRAIL;
                     end
                  end
               end
               TRAIL: begin
                  if (sclk_fall) begin
                     miso <= 1'b0;
                  end
               end
               default: begin
                  state   <= IDLE;
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
